md_unit: RTL and testbench
==========================

# md_unit

Multi-cycle multiply/divide unit in the EX stage of the five-stage MIPS pipeline, directly downstream of the ID/EX pipeline register. It consumes the latched operands (V1 = rs value, V2 = rt value) and the decoded MDControl/MDStart controls, and owns the architectural HI/LO registers. It exposes Busy and Stall so the hazard unit can hold dependent mult/div/mfhi/mflo/mthi/mtlo instructions in D.

## Interface
- MULT_CYCLES, 5, Busy duration in cycles for mult/multu
- DIV_CYCLES, 10, Busy duration in cycles for div/divu
- CLK  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low; clears all state immediately
- V1  input  32  operand A (rs), from ID/EX
- V2  input  32  operand B (rt), from ID/EX
- MDControl  input  2  00 mult, 01 multu, 10 div, 11 divu
- MDStart  input  1  start request for the operation in MDControl
- HIWrite  input  1  mthi: HI <= V1
- LOWrite  input  1  mtlo: LO <= V1
- Cancel  input  1  exception/interrupt taken on the instruction in EX; suppresses any start or write this cycle
- HI  output  32  HI register
- LO  output  32  LO register
- Busy  output  1  registered; operation in progress
- Stall  output  1  combinational: Busy | (MDStart & ~Cancel)

## Operation
- State: IDLE, RUN. Internal: 4-bit down-counter, latched 64-bit result, divide-by-zero flag.
- IDLE, MDStart=1, Cancel=0 at edge: compute result from V1/V2 per MDControl; latch it; counter <= MULT_CYCLES-1 or DIV_CYCLES-1; Busy <= 1; go RUN.
- RUN: counter decrements each edge. At the edge where counter is 0: commit result to {HI,LO}, Busy <= 0, go IDLE.
- mult: signed 32x32 -> 64, {HI,LO} = product. multu: unsigned.
- div: LO = quotient truncated toward zero, HI = remainder with sign of dividend (V1). divu: unsigned.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- Divisor 0 (div or divu): full DIV_CYCLES Busy period runs; HI and LO left unchanged at commit.
- HIWrite/LOWrite in IDLE with MDStart=0, Cancel=0: write V1 at that edge. Both asserted: both written.
- HIWrite/LOWrite in RUN: ignored. MDStart in RUN: ignored (hazard unit prevents both; no queuing).
- MDStart together with HIWrite/LOWrite: MDStart wins, writes ignored.
- Cancel=1: start and writes that edge suppressed. Cancel during RUN does not abort the running operation.
- MDControl/V1/V2 sampled only at the start edge; later changes have no effect.

## Timing
- Reset (reset=0, any time including mid-RUN): HI=0, LO=0, Busy=0, counter=0, state IDLE, pending result discarded. Stall follows inputs combinationally during reset and settles once Busy clears.
- Start accepted at edge k: Busy high from k through k+N (N = MULT_CYCLES or DIV_CYCLES), i.e. observed high for exactly N cycles. HI/LO take the new value at edge k+N, in the same edge that Busy falls.
- Back-to-back: a new MDStart sampled at edge k+N, with Busy still 1 before that edge, is ignored. Earliest accepted restart is edge k+N+1.
- Stall high in the start cycle (combinational) and for all N Busy cycles: N+1 cycles total.
- mthi/mtlo latency: 1 edge, no Busy.
- HI/LO readers (mfhi/mflo) see values directly; the hazard unit keeps them stalled while Stall=1.

## Test plan
- Reset, then mult V1=0xFFFFFFFF, V2=2 -> Busy high exactly 5 cycles; at commit HI=0xFFFFFFFF, LO=0xFFFFFFFE; Busy drops on the same edge.
- multu V1=0xFFFFFFFF, V2=2 -> HI=0x00000001, LO=0xFFFFFFFE.
- div V1=0xFFFFFFF9 (-7), V2=2 -> Busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu V1=7, V2=0 -> after 10 Busy cycles HI/LO keep their prior values. div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- mthi V1=0x12345678 in IDLE -> HI updates next edge, Busy stays 0. Pulse HIWrite/MDStart during RUN -> HI/LO and counter unaffected. Second MDStart at the commit edge -> ignored.
- MDStart with Cancel=1 -> Busy stays 0, HI/LO unchanged. Cancel pulsed mid-RUN -> operation still completes with the correct result.
- Assert reset=0 in cycle 3 of a div -> Busy, HI and LO go to 0 immediately (asynchronously). After release, no commit occurs.

Source files
------------

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Result is computed at the start edge and committed after a fixed busy period.
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [31:0] V1,
    input  logic [31:0] V2,
    input  logic [1:0]  MDControl,
    input  logic        MDStart,
    input  logic        HIWrite,
    input  logic        LOWrite,
    input  logic        Cancel,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        Busy,
    output logic        Stall
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] res_q, res_d;
    logic        dz_q, dz_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        start;
    logic [63:0] prod_s, prod_u, op_res;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, b_div, a_div;
    logic        div_zero, is_signed;

    assign start = (state_q == IDLE) & MDStart & ~Cancel;

    // Signed divide works on magnitudes, then restores signs; this also makes
    // 0x80000000 / -1 wrap to 0x80000000 with a zero remainder.
    always_comb begin
        is_signed = ~MDControl[0];
        div_zero  = (V2 == '0);
        prod_s    = {{32{V1[31]}}, V1} * {{32{V2[31]}}, V2};
        prod_u    = {32'd0, V1} * {32'd0, V2};
        a_mag     = V1[31] ? (~V1 + 32'd1) : V1;
        b_mag     = V2[31] ? (~V2 + 32'd1) : V2;
        a_div     = is_signed ? a_mag : V1;
        b_div     = div_zero ? 32'd1 : (is_signed ? b_mag : V2);
        q_mag     = a_div / b_div;
        r_mag     = a_div % b_div;
        op_res    = '0;
        case (MDControl)
            2'b00: op_res = prod_s;
            2'b01: op_res = prod_u;
            2'b10: begin
                op_res[31:0]  = (V1[31] ^ V2[31]) ? (~q_mag + 32'd1) : q_mag;
                op_res[63:32] = V1[31] ? (~r_mag + 32'd1) : r_mag;
            end
            default: op_res = {r_mag, q_mag};
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    res_d   = op_res;
                    dz_d    = MDControl[1] & div_zero;
                    cnt_d   = MDControl[1] ? 4'(DIV_CYCLES - 1) : 4'(MULT_CYCLES - 1);
                    state_d = RUN;
                end else if (!Cancel) begin
                    if (HIWrite) hi_d = V1;
                    if (LOWrite) lo_d = V1;
                end
            end
            RUN: begin
                if (cnt_q == '0) begin
                    if (!dz_q) begin
                        hi_d = res_q[63:32];
                        lo_d = res_q[31:0];
                    end
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign HI    = hi_q;
    assign LO    = lo_q;
    assign Busy  = (state_q == RUN);
    assign Stall = Busy | (MDStart & ~Cancel);

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: expected HI/LO and busy length are queued at
// each start and compared when Busy falls.
module tb_md_unit;

    logic        CLK;
    logic        reset;
    logic [31:0] V1, V2;
    logic [1:0]  MDControl;
    logic        MDStart, HIWrite, LOWrite, Cancel;
    logic [31:0] HI, LO;
    logic        Busy, Stall;

    typedef struct {
        logic [63:0] res;
        int          n;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] cur_hi, cur_lo;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .CLK(CLK), .reset(reset), .V1(V1), .V2(V2), .MDControl(MDControl),
        .MDStart(MDStart), .HIWrite(HIWrite), .LOWrite(LOWrite), .Cancel(Cancel),
        .HI(HI), .LO(LO), .Busy(Busy), .Stall(Stall)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] ctrl, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] hi,
                                          input logic [31:0] lo);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (ctrl)
            2'b00: return sa * sb;
            2'b01: begin
                p = ua * ub;
                return p;
            end
            2'b10: begin
                if (b == 32'd0) return {hi, lo};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {hi, lo};
                q = longint'(ua / ub);
                r = longint'(ua % ub);
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    // mode: 0 plain, 1 write/start interference mid-run, 2 Cancel mid-run,
    // 3 new start request held across the commit edge
    task automatic do_op(input string tag, input logic [1:0] ctrl, input logic [31:0] a,
                         input logic [31:0] b, input int mode);
        exp_t e;
        int   busy_cnt;
        int   cyc;
        @(negedge CLK);
        MDControl = ctrl; V1 = a; V2 = b; MDStart = 1'b1;
        #1 check_eq({tag, "_stall_start"}, 64'(Stall), 64'd1);
        e.res = model(ctrl, a, b, cur_hi, cur_lo);
        e.n   = ctrl[1] ? 10 : 5;
        sb_q.push_back(e);
        @(negedge CLK);
        MDStart = 1'b0; V1 = 32'h5A5A_A5A5; V2 = 32'h0000_0003; MDControl = ~ctrl;
        busy_cnt = 0;
        cyc = 0;
        while (Busy && cyc < 40) begin
            busy_cnt++;
            cyc++;
            if (busy_cnt == 1) check_eq({tag, "_stall_busy"}, 64'(Stall), 64'd1);
            HIWrite = 1'b0; LOWrite = 1'b0; Cancel = 1'b0; MDStart = 1'b0;
            if (mode == 1 && busy_cnt == 2) begin
                HIWrite = 1'b1; LOWrite = 1'b1; MDStart = 1'b1;
                MDControl = 2'b10; V1 = 32'hDEAD_BEEF; V2 = 32'd1;
            end
            if (mode == 2 && busy_cnt == 3) Cancel = 1'b1;
            if (mode == 3 && busy_cnt == e.n) begin
                MDStart = 1'b1; MDControl = 2'b01; V1 = 32'd3; V2 = 32'd3;
            end
            @(negedge CLK);
        end
        MDStart = 1'b0; HIWrite = 1'b0; LOWrite = 1'b0; Cancel = 1'b0;
        if (cyc >= 40) check_eq({tag, "_timeout"}, 64'(cyc), 64'd0);
        e = sb_q.pop_front();
        check_eq({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(e.n));
        check_eq({tag, "_hilo"}, {HI, LO}, e.res);
        cur_hi = e.res[63:32];
        cur_lo = e.res[31:0];
        if (mode == 3) begin
            @(negedge CLK);
            check_eq({tag, "_restart_ignored"}, 64'(Busy), 64'd0);
        end
    endtask

    task automatic move_to(input string tag, input logic hw, input logic lw, input logic [31:0] val);
        @(negedge CLK);
        HIWrite = hw; LOWrite = lw; V1 = val;
        @(negedge CLK);
        HIWrite = 1'b0; LOWrite = 1'b0;
        if (hw) cur_hi = val;
        if (lw) cur_lo = val;
        check_eq({tag, "_hilo"}, {HI, LO}, {cur_hi, cur_lo});
        check_eq({tag, "_busy"}, 64'(Busy), 64'd0);
    endtask

    initial begin
        exp_t d;
        reset = 1'b0; V1 = '0; V2 = '0; MDControl = '0;
        MDStart = 1'b0; HIWrite = 1'b0; LOWrite = 1'b0; Cancel = 1'b0;
        cur_hi = '0; cur_lo = '0;
        repeat (2) @(negedge CLK);
        check_eq("reset_hilo", {HI, LO}, 64'd0);
        check_eq("reset_busy", 64'(Busy), 64'd0);
        reset = 1'b1;

        do_op("mult",     2'b00, 32'hFFFF_FFFF, 32'd2, 0);
        check_eq("mult_const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFE);
        do_op("multu",    2'b01, 32'hFFFF_FFFF, 32'd2, 0);
        check_eq("multu_const", {HI, LO}, 64'h0000_0001_FFFF_FFFE);
        do_op("div",      2'b10, 32'hFFFF_FFF9, 32'd2, 0);
        check_eq("div_const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op("divu_z",   2'b11, 32'd7, 32'd0, 0);
        check_eq("divu_z_const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op("div_ovf",  2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check_eq("div_ovf_const", {HI, LO}, 64'h0000_0000_8000_0000);

        move_to("mthi", 1'b1, 1'b0, 32'h1234_5678);
        move_to("mtlo", 1'b0, 1'b1, 32'h0BAD_CAFE);
        move_to("mthilo", 1'b1, 1'b1, 32'hCAFE_F00D);

        do_op("interf",   2'b01, 32'h0001_0000, 32'h0001_0000, 1);
        do_op("cancelmid", 2'b11, 32'd100, 32'd7, 2);
        do_op("restart",  2'b00, 32'hFFFF_FFFE, 32'd3, 3);
        do_op("div_neg",  2'b10, 32'd7, 32'hFFFF_FFFE, 0);

        // start, mthi and Cancel together: nothing may happen
        @(negedge CLK);
        MDStart = 1'b1; HIWrite = 1'b1; Cancel = 1'b1; V1 = 32'h1111_2222; MDControl = 2'b00;
        #1 check_eq("cancel_stall", 64'(Stall), 64'd0);
        @(negedge CLK);
        MDStart = 1'b0; HIWrite = 1'b0; Cancel = 1'b0;
        check_eq("cancel_busy", 64'(Busy), 64'd0);
        check_eq("cancel_hilo", {HI, LO}, {cur_hi, cur_lo});

        // reset in the third busy cycle of a divide
        @(negedge CLK);
        MDControl = 2'b10; V1 = 32'd1000; V2 = 32'd3; MDStart = 1'b1;
        d.res = model(2'b10, 32'd1000, 32'd3, cur_hi, cur_lo);
        d.n = 10;
        sb_q.push_back(d);
        @(negedge CLK);
        MDStart = 1'b0;
        repeat (2) @(negedge CLK);
        check_eq("rst_pre_busy", 64'(Busy), 64'd1);
        #2 reset = 1'b0;
        #1;
        check_eq("rst_async_busy", 64'(Busy), 64'd0);
        check_eq("rst_async_hilo", {HI, LO}, 64'd0);
        d = sb_q.pop_front();
        cur_hi = '0; cur_lo = '0;
        @(negedge CLK);
        reset = 1'b1;
        repeat (15) @(negedge CLK);
        check_eq("rst_no_commit_hilo", {HI, LO}, 64'd0);
        check_eq("rst_no_commit_busy", 64'(Busy), 64'd0);
        check_eq("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
